// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin sharing of one shift-add multiplier between two
// requesters. The winner's operands are latched, the multiplier is started,
// and the product (or a watchdog error) is returned with a one-cycle Ack.
//
// Handshake (both ports): Req is a level held until the requester samples
// Ack=1, and it must drop at that same edge. Ack and Err are single-cycle
// pulses. P holds the port's last product until that port's next Ack. A Req
// still high in the next IDLE cycle counts as a new request.
module mult_arbiter #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Req0,
    input  logic [WIDTH-1:0]   A0,
    input  logic [WIDTH-1:0]   B0,
    output logic               Ack0,
    output logic [2*WIDTH-1:0] P0,
    output logic               Err0,
    input  logic               Req1,
    input  logic [WIDTH-1:0]   A1,
    input  logic [WIDTH-1:0]   B1,
    output logic               Ack1,
    output logic [2*WIDTH-1:0] P1,
    output logic               Err1,
    output logic               Mul_St,
    output logic [WIDTH-1:0]   Mul_A,
    output logic [WIDTH-1:0]   Mul_B,
    input  logic               Mul_Idle,
    input  logic               Mul_Done,
    input  logic [2*WIDTH-1:0] Mul_P,
    output logic               Busy,
    output logic               Owner,
    output logic [1:0]         State
);

    // Watchdog only needs to count up to TIMEOUT-1.
    localparam int WD_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            last;
    logic            owner;
    logic            err;
    logic [WD_W-1:0] wd;
    logic            grant;
    logic            winner;
    logic            run_timeout;

    // Arbitration and watchdog terminal-count decode.
    always_comb begin
        grant       = Mul_Idle & (Req0 | Req1);
        winner      = (Req0 & Req1) ? ~last : Req1;
        run_timeout = (wd == WD_W'(TIMEOUT - 1));
    end

    // Next-state decode; Mul_Done outranks the watchdog in RUN.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant) state_nxt = LOAD;
            LOAD:    state_nxt = RUN;
            RUN:     if (Mul_Done || run_timeout) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge Clk) begin
        if (Rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Operand latch, ownership, watchdog and per-port result registers.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            Mul_A <= '0;
            Mul_B <= '0;
            owner <= 1'b0;
            last  <= 1'b1;
            wd    <= '0;
            err   <= 1'b0;
            P0    <= '0;
            P1    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        Mul_A <= winner ? A1 : A0;
                        Mul_B <= winner ? B1 : B0;
                        owner <= winner;
                    end
                end
                LOAD: wd <= '0;
                RUN: begin
                    if (Mul_Done) begin
                        err <= 1'b0;
                        if (owner) P1 <= Mul_P;
                        else       P0 <= Mul_P;
                    end else if (run_timeout) begin
                        err <= 1'b1;
                        if (owner) P1 <= '0;
                        else       P0 <= '0;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                RESP: last <= owner;
                default: ;
            endcase
        end
    end

    // State-decoded strobes and status.
    always_comb begin
        Mul_St = (state == LOAD);
        Ack0   = (state == RESP) & ~owner;
        Ack1   = (state == RESP) & owner;
        Err0   = Ack0 & err;
        Err1   = Ack1 & err;
        Busy   = (state != IDLE);
        Owner  = owner;
        State  = state;
    end

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter with a behavioural multiplier model that
// raises Done a fixed number of edges after sampling St.
module tb_mult_arbiter;

    localparam int W = 16;

    logic           Clk = 1'b0;
    logic           Rst;
    logic           Req0, Req1;
    logic [W-1:0]   A0, B0, A1, B1;
    logic           Ack0, Ack1, Err0, Err1;
    logic [2*W-1:0] P0, P1;
    logic           Mul_St, Mul_Idle, Mul_Done;
    logic [W-1:0]   Mul_A, Mul_B;
    logic [2*W-1:0] Mul_P;
    logic           Busy, Owner;
    logic [1:0]     State;

    int tests = 0;
    int fails = 0;

    // Multiplier model controls.
    int             m_cnt  = 0;
    logic           m_done = 1'b0;
    logic [2*W-1:0] m_p    = '0;
    logic           m_hang = 1'b0;
    logic           m_block = 1'b0;
    logic           m_spur = 1'b0;

    always #5 Clk = ~Clk;

    mult_arbiter #(.WIDTH(W), .TIMEOUT(8)) dut (
        .Clk(Clk), .Rst(Rst),
        .Req0(Req0), .A0(A0), .B0(B0), .Ack0(Ack0), .P0(P0), .Err0(Err0),
        .Req1(Req1), .A1(A1), .B1(B1), .Ack1(Ack1), .P1(P1), .Err1(Err1),
        .Mul_St(Mul_St), .Mul_A(Mul_A), .Mul_B(Mul_B),
        .Mul_Idle(Mul_Idle), .Mul_Done(Mul_Done), .Mul_P(Mul_P),
        .Busy(Busy), .Owner(Owner), .State(State)
    );

    // Behavioural multiplier: St sampled at edge e -> Done high after edge e+4.
    always @(posedge Clk) begin
        m_done <= 1'b0;
        if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1 && !m_hang) m_done <= 1'b1;
        end else if (Mul_St) begin
            m_cnt <= 4;
            m_p   <= Mul_A * Mul_B;
        end
    end

    assign Mul_Idle = (m_cnt == 0) && !m_done && !m_block;
    assign Mul_Done = m_done | m_spur;
    assign Mul_P    = m_spur ? 32'hDEAD_BEEF : m_p;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Tick until an Ack appears (bounded); port=-1 on expiry, 2 if both ack.
    task automatic wait_ack(output int lat, output int port, output int st_cnt);
        lat = 0; port = -1; st_cnt = 0;
        while (lat < 60 && port < 0) begin
            tick();
            lat++;
            if (Mul_St) st_cnt++;
            if (Ack0 && Ack1) port = 2;
            else if (Ack0)    port = 0;
            else if (Ack1)    port = 1;
        end
    endtask

    initial begin
        int lat, port, st;
        int exp_owner;

        Rst = 1'b1; Req0 = 1'b0; Req1 = 1'b0;
        A0 = '0; B0 = '0; A1 = '0; B1 = '0;

        // Reset with Req0 already pending.
        A0 = 16'd3; B0 = 16'd5; Req0 = 1'b1;
        tick(); tick();
        check("rst_busy",  Busy, 0);
        check("rst_owner", Owner, 0);
        check("rst_acks",  {Ack0, Ack1, Err0, Err1, Mul_St}, 0);
        check("rst_p",     {P0, P1}, 0);
        check("rst_mul",   {Mul_A, Mul_B}, 0);
        Rst = 1'b0;

        // Single request: 3 x 5, grant at first edge, Ack 6 edges later.
        wait_ack(lat, port, st);
        check("single_port", port, 0);
        check("single_lat",  lat, 7);
        check("single_st",   st, 1);
        check("single_mul",  {Mul_A, Mul_B}, {16'd3, 16'd5});
        check("single_p0",   P0, 32'd15);
        check("single_err",  {Err0, Err1}, 0);
        Req0 = 1'b0; A0 = 16'd7;
        tick();
        check("single_pulse", {Ack0, Ack1}, 0);
        check("hold_mul_a",   Mul_A, 16'd3);
        check("hold_p0",      P0, 32'd15);

        // Width corner on port 1.
        A1 = 16'hFFFF; B1 = 16'hFFFF; Req1 = 1'b1;
        wait_ack(lat, port, st);
        check("wide_port", port, 1);
        check("wide_p1",   P1, 32'hFFFE0001);
        check("wide_p0",   P0, 32'd15);
        check("wide_err",  {Err0, Err1}, 0);
        Req1 = 1'b0;
        tick();

        // Fairness: both held, last grant went to port 1 -> 0,1,0,1.
        A0 = 16'd2; B0 = 16'd3; A1 = 16'd4; B1 = 16'd5;
        Req0 = 1'b1; Req1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_owner = i % 2;
            wait_ack(lat, port, st);
            check("fair_port",  port, exp_owner);
            check("fair_owner", Owner, exp_owner);
            if (exp_owner == 0) check("fair_p0", P0, 32'd6);
            else                check("fair_p1", P1, 32'd20);
        end
        Req0 = 1'b0; Req1 = 1'b0;
        tick();

        // Timeout: RUN entered at 2nd edge, Ack+Err 8 edges later.
        m_hang = 1'b1;
        A0 = 16'd9; B0 = 16'd9; Req0 = 1'b1;
        wait_ack(lat, port, st);
        check("to_port", port, 0);
        check("to_lat",  lat, 10);
        check("to_err",  {Err0, Err1}, 2'b10);
        check("to_p0",   P0, 0);
        Req0 = 1'b0; m_hang = 1'b0;
        tick();
        A0 = 16'd6; B0 = 16'd7; Req0 = 1'b1;
        wait_ack(lat, port, st);
        check("after_to_port", port, 0);
        check("after_to_err",  Err0, 0);
        check("after_to_p0",   P0, 32'd42);
        Req0 = 1'b0;
        tick();

        // Blocking: multiplier not idle, plus a stray Done while IDLE.
        m_block = 1'b1;
        A0 = 16'd1; B0 = 16'd1; Req0 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            m_spur = (i == 2);
            tick();
            check("blk_busy", {Busy, Mul_St, Ack0, Ack1}, 0);
        end
        m_spur = 1'b0;
        check("blk_p0", P0, 32'd42);
        m_block = 1'b0;
        wait_ack(lat, port, st);
        check("unblk_port", port, 0);
        check("unblk_lat",  lat, 7);
        check("unblk_p0",   P0, 32'd1);
        Req0 = 1'b0;
        tick();

        // Abort in RUN: no Ack/Err, in-flight Done ignored afterwards.
        A1 = 16'd2; B1 = 16'd2; Req1 = 1'b1;
        tick(); tick(); tick();
        check("abort_in_run", State, 2'd2);
        Rst = 1'b1;
        tick();
        Rst = 1'b0; Req1 = 1'b0;
        check("abort_busy", Busy, 0);
        for (int i = 0; i < 8; i++) begin
            check("abort_quiet", {Busy, Ack0, Ack1, Err0, Err1}, 0);
            tick();
        end
        check("abort_p1", P1, 0);
        A1 = 16'd3; B1 = 16'd3; Req1 = 1'b1;
        wait_ack(lat, port, st);
        check("post_abort_port", port, 1);
        check("post_abort_p1",   P1, 32'd9);
        check("post_abort_err",  Err1, 0);
        Req1 = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mult_arbiter.md
Name: mult_arbiter

Overview:
- Shares one shift-add multiplier unit between two requesters: the CPU mult path (port 0) and an auxiliary requester (port 1).
- Arbitrates round-robin and latches the winner's operands.
- Sequences the multiplier through start, run and done, and routes the product back to the owner with a one-cycle acknowledge.
- Includes a watchdog that returns an error if the multiplier never reports completion.

Parameters:
- WIDTH, 16: operand width; product is 2*WIDTH.
- TIMEOUT, 64: maximum cycles spent in RUN before aborting with error (must be >= 2).

Ports:
- Clk  in  1  clock, rising edge.
- Rst  in  1  synchronous reset, active-high.
- Req0  in  1  request from port 0; level, held until Ack0.
- A0  in  WIDTH  multiplicand, port 0.
- B0  in  WIDTH  multiplier, port 0.
- Ack0  out  1  one-cycle completion pulse, port 0.
- P0  out  2*WIDTH  product register, port 0.
- Err0  out  1  timeout flag, valid with Ack0.
- Req1, A1, B1, Ack1, P1, Err1: same as port 0, for port 1.
- Mul_St  out  1  start pulse to the multiplier.
- Mul_A  out  WIDTH  latched multiplicand to the multiplier.
- Mul_B  out  WIDTH  latched multiplier to the multiplier.
- Mul_Idle  in  1  multiplier is idle and ready to accept St.
- Mul_Done  in  1  multiplier product is valid this cycle.
- Mul_P  in  2*WIDTH  multiplier product.
- Busy  out  1  high whenever state != IDLE.
- Owner  out  1  index of the current or last granted port.

Behaviour:
- Reset (Rst=1 at a rising edge):
  - state=IDLE; Ack0/1=0, Err0/1=0; P0/P1=0; Mul_A/Mul_B=0; Owner=0; Last=1, so port 0 wins the first tie; watchdog=0.
  - Rst mid-operation aborts silently: no Ack, no Err.
  - The multiplier itself is not reset by this block. IDLE waits for Mul_Idle before granting again, so an in-flight product is discarded.
- FSM states: IDLE, LOAD, RUN, RESP.
- IDLE:
  - Grants when Mul_Idle=1 and (Req0 | Req1).
  - Winner: the sole requester; if both request, the port != Last.
  - At the grant edge: latch the winner's A/B into Mul_A/Mul_B, set Owner=winner, go to LOAD.
  - Mul_Idle=0 blocks granting. Mul_Done is ignored.
- LOAD:
  - Mul_St=1, decoded from state, for exactly this one cycle.
  - Clear the watchdog; go to RUN.
- RUN:
  - If Mul_Done=1: capture Mul_P into the result register, err=0, go to RESP.
  - Else if watchdog == TIMEOUT-1: result=0, err=1, go to RESP.
  - Else watchdog+1.
  - Mul_Done wins over timeout in the same cycle.
- RESP:
  - Ack[Owner]=1 and Err[Owner]=err for this one cycle. The Ack/Err of the other port stays 0.
  - P[Owner] is updated at the edge entering RESP, so it is valid during Ack and held until that port's next Ack. The other port's P is untouched.
  - Last<=Owner; go to IDLE.
- Mul_A/Mul_B hold their latched values in all states. Requester operand changes after the grant have no effect.
- Requester handshake:
  - A requester must drop Req at the edge where it samples Ack=1.
  - A Req still high in the following IDLE cycle is a new request. Round-robin then applies: if both ports are requesting, the other port wins.
- Multiplication semantics (unsigned, WIDTH x WIDTH -> 2*WIDTH) belong to the multiplier. This block only passes Mul_P through unmodified.
- Latency:
  - Req sampled in IDLE at edge k -> Mul_St high during cycle k+1.
  - Ack = k + 3 + N cycles, where N = cycles from Mul_St until Mul_Done.
- Error latency: Ack with Err=1 exactly TIMEOUT cycles after entering RUN.
- No combinational path from Req/A/B to any output. Only Mul_St, Ack and Err are state-decoded.

Test Plan:
- Reset: hold Rst 2 cycles -> all outputs 0, Busy=0, Owner=0; a Req0 asserted during Rst is not granted until after Rst falls.
- Single request: Req0, A0=3, B0=5, behavioural multiplier (Done 4 cycles after St) -> Mul_St one cycle, Mul_A=3, Mul_B=5, Ack0 one pulse at cycle k+7, P0=15, Err0=0, Ack1 never asserted.
- Width corner: Req1, A1=B1=16'hFFFF -> P1=32'hFFFE0001, P0 unchanged from its previous value.
- Fairness: Req0 and Req1 held continuously after reset for 4 transactions -> Owner sequence 0,1,0,1; each Ack alternates; no port starved.
- Timeout: TIMEOUT=8, multiplier never asserts Done -> Ack0=1 and Err0=1 exactly 8 cycles after entering RUN, P0=0; next request served normally with Err0=0.
- Blocking and abort:
  - Mul_Idle=0 with Req0 pending -> Busy stays 0 and no Mul_St until Mul_Idle=1.
  - Mul_Done pulse while IDLE -> ignored.
  - Rst asserted in RUN -> Busy=0 next cycle, no Ack/Err emitted.
